// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer:
// ALU op codes, sequencer state encoding and op classification helpers.
package mdu_pkg;

    localparam int unsigned WORDSIZE = 32;
    localparam int unsigned OP_W     = 5;

    localparam logic [OP_W-1:0] ALU_MUL    = 5'd16;
    localparam logic [OP_W-1:0] ALU_MULH   = 5'd17;
    localparam logic [OP_W-1:0] ALU_MULHSU = 5'd18;
    localparam logic [OP_W-1:0] ALU_MULHU  = 5'd19;
    localparam logic [OP_W-1:0] ALU_DIV    = 5'd20;
    localparam logic [OP_W-1:0] ALU_DIVU   = 5'd21;
    localparam logic [OP_W-1:0] ALU_REM    = 5'd22;
    localparam logic [OP_W-1:0] ALU_REMU   = 5'd23;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIX  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_e;

    function automatic logic mdu_is_m(input logic [OP_W-1:0] op);
        return op[4:3] == 2'b10;
    endfunction

    function automatic logic mdu_is_div(input logic [OP_W-1:0] op);
        return mdu_is_m(op) && op[2];
    endfunction

    function automatic logic mdu_is_rem(input logic [OP_W-1:0] op);
        return mdu_is_div(op) && op[1];
    endfunction

    function automatic logic mdu_rs1_signed(input logic [OP_W-1:0] op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    endfunction

    function automatic logic mdu_rs2_signed(input logic [OP_W-1:0] op);
        return op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the shared datapath: shift-add multiply (LSB first) or
// restoring radix-2 divide (MSB first) on a 2*WIDTH+1 bit accumulator.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = WORDSIZE
) (
    input  logic [2*WIDTH:0] acc,
    input  logic [WIDTH-1:0] opnd,
    input  logic             div_mode,
    output logic [2*WIDTH:0] acc_nxt,
    output logic             q_bit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Multiply: {hi, multiplier}; divide: {partial remainder, dividend/quotient}.
    always_comb begin
        sum     = acc[2*WIDTH:WIDTH] + ({1'b0, opnd} & {(WIDTH+1){acc[0]}});
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        trial   = shifted - {1'b0, opnd};
        q_bit   = 1'b0;
        acc_nxt = {1'b0, sum, acc[WIDTH-1:1]};
        if (div_mode) begin
            q_bit   = (shifted >= {1'b0, opnd});
            acc_nxt = {(q_bit ? trial : shifted), acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer: FSM, iteration counter, operand
// sign handling and result selection around the mdu_step datapath.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = WORDSIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             kill,
    input  logic [4:0]       ops,
    input  logic [WIDTH-1:0] read1,
    input  logic [WIDTH-1:0] read2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    mdu_state_e       state_q, state_d;
    logic [4:0]       op_q, op_d;
    logic             neg1_q, neg1_d, neg2_q, neg2_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [2*WIDTH:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_d, done_d;
    logic [WIDTH-1:0] result_d;

    logic             div_mode;
    logic [2*WIDTH:0] step_acc;
    logic             step_q;
    logic             s_neg1, s_neg2, ovf;
    logic [WIDTH-1:0] mag1, mag2, quo, rem;
    logic [2*WIDTH-1:0] prod;

    assign div_mode = mdu_is_div(op_q);

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_q),
        .opnd     (opnd_q),
        .div_mode (div_mode),
        .acc_nxt  (step_acc),
        .q_bit    (step_q)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result;

        s_neg1 = mdu_rs1_signed(ops) && read1[WIDTH-1];
        s_neg2 = mdu_rs2_signed(ops) && read2[WIDTH-1];
        mag1   = s_neg1 ? -read1 : read1;
        mag2   = s_neg2 ? -read2 : read2;
        ovf    = mdu_is_div(ops) && mdu_rs2_signed(ops) && (read1 == SMIN) && (read2 == '1);

        prod = acc_q[2*WIDTH-1:0];
        if (neg1_q ^ neg2_q) prod = -prod;
        quo = acc_q[WIDTH-1:0];
        if (neg1_q ^ neg2_q) quo = -quo;
        rem = acc_q[2*WIDTH-1:WIDTH];
        if (neg1_q) rem = -rem;

        case (state_q)
            MDU_IDLE, MDU_DONE: begin
                state_d = MDU_IDLE;
                if (start && mdu_is_m(ops)) begin
                    op_d   = ops;
                    neg1_d = s_neg1;
                    neg2_d = s_neg2;
                    cnt_d  = '0;
                    if (mdu_is_div(ops) && (read2 == '0)) begin
                        result_d = mdu_is_rem(ops) ? read1 : '1;
                        state_d  = MDU_DONE;
                    end else if (ovf) begin
                        result_d = mdu_is_rem(ops) ? '0 : SMIN;
                        state_d  = MDU_DONE;
                    end else begin
                        // Divide keeps the divisor as operand; multiply keeps the multiplicand.
                        opnd_d  = mdu_is_div(ops) ? mag2 : mag1;
                        acc_d   = {{(WIDTH+1){1'b0}}, (mdu_is_div(ops) ? mag1 : mag2)};
                        state_d = MDU_CALC;
                    end
                end
            end
            MDU_CALC: begin
                acc_d = div_mode ? {step_acc[2*WIDTH:1], step_q} : step_acc;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = MDU_FIX;
                end
            end
            MDU_FIX: begin
                if (div_mode)
                    result_d = mdu_is_rem(op_q) ? rem : quo;
                else
                    result_d = (op_q == ALU_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
                state_d = MDU_DONE;
            end
            default: state_d = MDU_IDLE;
        endcase

        if (kill) begin
            state_d  = MDU_IDLE;
            result_d = result;
        end

        busy_d = (state_d == MDU_CALC) || (state_d == MDU_FIX);
        done_d = (state_d == MDU_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MDU_IDLE;
            op_q    <= '0;
            neg1_q  <= 1'b0;
            neg2_q  <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg1_q  <= neg1_d;
            neg2_q  <= neg2_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;
            done    <= done_d;
            result  <= result_d;
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: directed RV32M cases plus randomized ops
// against an arithmetic reference model, checking result and done timing.
module tb_mdu_seq;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, start, kill;
    logic [4:0]  ops;
    logic [31:0] read1, read2;
    logic        busy, done;
    logic [31:0] result;

    mdu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .ops(ops),
        .read1(read1), .read2(read2), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          due;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          edges = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] last_exp = '0;

    always @(posedge clk) edges++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, expv, edges);
        end
    endtask

    function automatic bit is_div_op(input logic [4:0] op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    function automatic bit is_fast(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!is_div_op(op)) return 1'b0;
        if (b == 32'd0) return 1'b1;
        return (op inside {ALU_DIV, ALU_REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] ref_mdu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sbv, ua, ub, p;
        logic signed [31:0] as32, bs32;
        sa = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        as32 = a;
        bs32 = b;
        p = '0;
        case (op)
            ALU_MUL:    begin p = sa * sbv; return p[31:0];  end
            ALU_MULH:   begin p = sa * sbv; return p[63:32]; end
            ALU_MULHSU: begin p = sa * ub;  return p[63:32]; end
            ALU_MULHU:  begin p = ua * ub;  return p[63:32]; end
            ALU_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return as32 / bs32;
            end
            ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return as32 % bs32;
            end
            ALU_REMU: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always begin
        @(posedge clk);
        #1;
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, result, e.res);
                check({e.name, "_done_edge"}, edges, e.due);
                last_exp = e.res;
            end
        end
    end

    // Called at a negedge; returns at the following negedge with start low.
    task automatic issue(input string name, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        bit   fast;
        start = 1'b1;
        ops   = op;
        read1 = a;
        read2 = b;
        fast  = is_fast(op, a, b);
        if (op[4:3] == 2'b10) begin
            e.res  = ref_mdu(op, a, b);
            e.due  = edges + 1 + (fast ? 0 : 33);
            e.name = name;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy"}, 32'(busy), 32'((op[4:3] == 2'b10) && !fast));
    endtask

    // Wait for the scoreboard to drain; optionally scramble inputs while busy.
    task automatic drain(input bit scramble);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            if (scramble && busy) begin
                start = 1'($urandom_range(0, 1));
                ops   = 5'($urandom_range(0, 31));
                read1 = $urandom;
                read2 = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; ops = '0; read1 = '0; read2 = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue("mulh_neg", ALU_MULH, 32'hFFFF_FFFE, 32'h0000_0003); drain(1'b0);
        issue("mul_neg",  ALU_MUL,  32'hFFFF_FFFE, 32'h0000_0003); drain(1'b0);
        issue("div_neg",  ALU_DIV,  32'hFFFF_FFF9, 32'd2);         drain(1'b0);
        issue("rem_neg",  ALU_REM,  32'hFFFF_FFF9, 32'd2);         drain(1'b0);
        issue("mulhu_max", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); drain(1'b0);
        issue("mulhsu",   ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); drain(1'b0);
        issue("divu_zero", ALU_DIVU, 32'd5, 32'd0);                drain(1'b0);
        issue("remu_zero", ALU_REMU, 32'd5, 32'd0);                drain(1'b0);
        issue("div_ovf",  ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF); drain(1'b0);
        issue("rem_ovf",  ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF); drain(1'b0);
        issue("non_m",    5'd3,     32'd9, 32'd9);                 drain(1'b0);
        @(negedge clk);

        // Kill partway through a divide: no done, result held.
        issue("divu_killed", ALU_DIVU, 32'd100, 32'd7);
        repeat (8) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        sb.delete();
        repeat (40) @(negedge clk);
        check("kill_busy", 32'(busy), 32'd0);
        check("kill_result_held", result, last_exp);

        issue("divu_after_kill", ALU_DIVU, 32'd100, 32'd7); drain(1'b0);
        issue("remu_after_kill", ALU_REMU, 32'd100, 32'd7); drain(1'b0);

        // Back-to-back: second start lands in the DONE cycle of the first.
        issue("b2b_first", ALU_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
        drain(1'b0);
        check("b2b_in_done_cycle", 32'(done), 32'd1);
        issue("b2b_second", ALU_DIVU, 32'hDEAD_BEEF, 32'd13);
        drain(1'b0);

        // Reset during CALC discards the operation and clears outputs.
        issue("rst_victim", ALU_MUL, 32'd1234, 32'd5678);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        check("rst_calc_busy", 32'(busy), 32'd0);
        check("rst_calc_done", 32'(done), 32'd0);
        check("rst_calc_result", result, 32'd0);
        last_exp = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            logic [4:0] op;
            op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(16, 23));
            issue("rand", op, rand_operand(), rand_operand());
            drain(1'b1);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("final_queue_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
